// File: rtl/irq_trap_controller_pkg.sv
//==============================================================================
// Module   : irq_pkg
// Brief    : Shared constants and state type for the interrupt trap
//            controller (cause codes, mcause interrupt bit, mtvec modes).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package irq_pkg;

  // Reference data width the mcause interrupt-bit position is derived from
  localparam int unsigned IRQ_XLEN       = 32;
  localparam int unsigned MCAUSE_INT_BIT = IRQ_XLEN - 1;

  // Machine-level interrupt cause codes
  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  // mtvec[1:0] modes; the reserved encodings behave as direct
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // Trap negotiation states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2,
    DONE    = 2'd3
  } irq_state_e;

endpackage : irq_pkg

`default_nettype wire

// File: rtl/irq_trap_controller_if.sv
//==============================================================================
// Module   : irq_trap_controller_if
// Brief    : Request/acknowledge link between interrupt_arbiter (master) and
//            the core-side trap controller (slave).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface irq_trap_controller_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) ();

  logic               irq_i;
  logic [CAUSE_W-1:0] irq_cause_i;
  logic [XLEN-1:0]    irq_extra_i;
  logic               irq_ack_o;
  logic               irq_complete_o;

  // Arbiter side: raises requests, receives the handshake pulses
  modport master (
    output irq_i,
    output irq_cause_i,
    output irq_extra_i,
    input  irq_ack_o,
    input  irq_complete_o
  );

  // Controller side: consumes requests, returns the handshake pulses
  modport slave (
    input  irq_i,
    input  irq_cause_i,
    input  irq_extra_i,
    output irq_ack_o,
    output irq_complete_o
  );

endinterface : irq_trap_controller_if

`default_nettype wire

// File: rtl/irq_trap_controller_latency_counter.sv
//==============================================================================
// Module   : irq_latency_counter
// Brief    : Measures how many cycles a trap request waits in REQ before the
//            pipeline accepts it; keeps the last and the worst value seen.
//            Only compiled when IRQ_LATENCY_STATS_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifdef IRQ_LATENCY_STATS_EN
module irq_latency_counter #(
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,    // IDLE -> REQ transition this cycle
  input  logic             in_req_i,   // controller currently in REQ
  input  logic             take_i,     // take_ack_i accepted in REQ
  output logic [LAT_W-1:0] lat_last_o,
  output logic [LAT_W-1:0] lat_max_o
);

  localparam logic [LAT_W-1:0] c_sat = '1;

  logic [LAT_W-1:0] r_count;

  // Wait counter: cleared on request entry, saturating while the request waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (start_i) begin
      r_count <= '0;
    end else if (in_req_i && !take_i && (r_count != c_sat)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Statistics only move on an accepted trap; abandoned requests leave them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_last_o <= '0;
      lat_max_o  <= '0;
    end else if (take_i) begin
      lat_last_o <= r_count;
      if (r_count > lat_max_o) begin
        lat_max_o <= r_count;
      end
    end
  end

endmodule : irq_latency_counter
`endif

`default_nettype wire

// File: rtl/irq_trap_controller.sv
//==============================================================================
// Module   : irq_trap_controller
// Brief    : Core-side responder to the interrupt arbiter. Qualifies requests
//            against the CSR enables, negotiates a trap with the pipeline,
//            produces mepc/mcause/redirect values and returns ack/complete
//            pulses. One trap in flight at a time (no nesting).
// Options  : IRQ_LATENCY_STATS_EN adds lat_last_o / lat_max_o request-wait
//            statistics (parameter LAT_W).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_trap_controller
  import irq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
`ifdef IRQ_LATENCY_STATS_EN
  ,
  parameter int LAT_W   = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irq_trap_controller_if.slave  arb,
  input  logic                  mstatus_mie_i,
  input  logic [XLEN-1:0]       mie_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic [XLEN-1:0]       epc_i,
  output logic                  take_req_o,
  input  logic                  take_ack_i,
  output logic [XLEN-1:0]       redirect_pc_o,
  output logic                  trap_enter_o,
  output logic [XLEN-1:0]       mepc_o,
  output logic [XLEN-1:0]       mcause_o,
  output logic [XLEN-1:0]       irq_id_o,
  input  logic                  mret_i,
  output logic                  trap_exit_o,
  output logic                  in_handler_o
`ifdef IRQ_LATENCY_STATS_EN
  ,
  output logic [LAT_W-1:0]      lat_last_o,
  output logic [LAT_W-1:0]      lat_max_o
`endif
);

  irq_state_e         r_state;
  logic [CAUSE_W-1:0] r_cause;
  logic [XLEN-1:0]    r_extra;

  logic               w_qual;
  logic [XLEN-1:0]    w_mcause;
  logic [XLEN-1:0]    w_base;
  logic [XLEN-1:0]    w_vec_off;
  logic [XLEN-1:0]    w_redirect;

  // Request qualification and trap-entry values derived from the latched cause
  always_comb begin
    w_qual     = arb.irq_i & mstatus_mie_i & mie_i[arb.irq_cause_i];
    w_mcause   = {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, r_cause};
    w_base     = {mtvec_i[XLEN-1:2], 2'b00};
    w_vec_off  = {{(XLEN-CAUSE_W-2){1'b0}}, r_cause, 2'b00};
    w_redirect = (mtvec_i[1:0] == MTVEC_MODE_VECTORED) ? (w_base + w_vec_off) : w_base;
  end

  // Trap FSM with registered handshake, CSR and redirect outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_cause            <= '0;
      r_extra            <= '0;
      take_req_o         <= 1'b0;
      trap_enter_o       <= 1'b0;
      trap_exit_o        <= 1'b0;
      in_handler_o       <= 1'b0;
      arb.irq_ack_o      <= 1'b0;
      arb.irq_complete_o <= 1'b0;
      redirect_pc_o      <= '0;
      mepc_o             <= '0;
      mcause_o           <= '0;
      irq_id_o           <= '0;
    end else begin
      // Pulse outputs fall back to zero unless a transition below raises them
      trap_enter_o       <= 1'b0;
      trap_exit_o        <= 1'b0;
      arb.irq_ack_o      <= 1'b0;
      arb.irq_complete_o <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_qual) begin
            r_cause    <= arb.irq_cause_i;
            r_extra    <= arb.irq_extra_i;
            r_state    <= REQ;
            take_req_o <= 1'b1;
          end
        end

        REQ: begin
          // Pipeline acceptance takes priority over a simultaneous irq drop
          if (take_ack_i) begin
            r_state       <= HANDLER;
            take_req_o    <= 1'b0;
            in_handler_o  <= 1'b1;
            trap_enter_o  <= 1'b1;
            arb.irq_ack_o <= 1'b1;
            mepc_o        <= epc_i;
            mcause_o      <= w_mcause;
            irq_id_o      <= r_extra;
            redirect_pc_o <= w_redirect;
          end else if (!arb.irq_i || !mstatus_mie_i) begin
            r_state    <= IDLE;
            take_req_o <= 1'b0;
          end
        end

        HANDLER: begin
          if (mret_i) begin
            r_state            <= DONE;
            in_handler_o       <= 1'b0;
            trap_exit_o        <= 1'b1;
            arb.irq_complete_o <= 1'b1;
          end
        end

        DONE: begin
          // Cooldown so the arbiter can retire the source before irq_i is resampled
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef IRQ_LATENCY_STATS_EN
  logic w_lat_start;
  logic w_lat_in_req;
  logic w_lat_take;

  // Latency counter event strobes taken from the FSM's view of the handshake
  always_comb begin
    w_lat_start  = (r_state == IDLE) & w_qual;
    w_lat_in_req = (r_state == REQ);
    w_lat_take   = (r_state == REQ) & take_ack_i;
  end

  irq_latency_counter #(
    .LAT_W (LAT_W)
  ) u_latency (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (w_lat_start),
    .in_req_i   (w_lat_in_req),
    .take_i     (w_lat_take),
    .lat_last_o (lat_last_o),
    .lat_max_o  (lat_max_o)
  );
`endif

endmodule : irq_trap_controller

`default_nettype wire

// File: tb/tb_irq_trap_controller.sv
//==============================================================================
// Module   : tb_irq_trap_controller
// Brief    : Self-checking bench for irq_trap_controller: a trap-level
//            reference model compared every cycle, plus directed scenarios
//            with hand-computed literal expectations.
// Options  : IRQ_LATENCY_STATS_EN enables the latency statistics scenario.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_irq_trap_controller;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mstatus_mie;
  logic [31:0] mie_vec;
  logic [31:0] mtvec;
  logic [31:0] epc;
  logic        take_req;
  logic        take_ack;
  logic [31:0] redirect_pc;
  logic        trap_enter;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] irq_id;
  logic        mret;
  logic        trap_exit;
  logic        in_handler;
`ifdef IRQ_LATENCY_STATS_EN
  logic [15:0] lat_last;
  logic [15:0] lat_max;
`endif

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  irq_trap_controller_if #(.XLEN(32), .CAUSE_W(5)) arb_if ();

  irq_trap_controller #(
    .XLEN    (32),
    .CAUSE_W (5)
`ifdef IRQ_LATENCY_STATS_EN
    ,
    .LAT_W   (16)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb           (arb_if),
    .mstatus_mie_i (mstatus_mie),
    .mie_i         (mie_vec),
    .mtvec_i       (mtvec),
    .epc_i         (epc),
    .take_req_o    (take_req),
    .take_ack_i    (take_ack),
    .redirect_pc_o (redirect_pc),
    .trap_enter_o  (trap_enter),
    .mepc_o        (mepc),
    .mcause_o      (mcause),
    .irq_id_o      (irq_id),
    .mret_i        (mret),
    .trap_exit_o   (trap_exit),
    .in_handler_o  (in_handler)
`ifdef IRQ_LATENCY_STATS_EN
    ,
    .lat_last_o    (lat_last),
    .lat_max_o     (lat_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Trap target from the mtvec rules: aligned base, plus 4*cause when vectored
  function automatic logic [31:0] exp_redirect(input logic [31:0] tv, input logic [4:0] cause);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (tv[1:0] == 2'd1) return base + 32'(cause) * 32'd4;
    return base;
  endfunction

  // ---------------- reference model (trap-level view) ----------------
  // m_phase: 0 = waiting for a request, 1 = requesting the pipeline,
  //          2 = handler running, 3 = cooldown after mret
  int          m_phase = 0;
  logic [4:0]  m_cause = '0;
  logic [31:0] m_extra = '0;
  logic        e_take_req = 0, e_ack = 0, e_complete = 0, e_enter = 0, e_exit = 0, e_inh = 0;
  logic [31:0] e_mepc = '0, e_mcause = '0, e_id = '0, e_redirect = '0;
  int          m_wait = 0, e_lat_last = 0, e_lat_max = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cause = '0; m_extra = '0;
      e_take_req = 0; e_ack = 0; e_complete = 0; e_enter = 0; e_exit = 0; e_inh = 0;
      e_mepc = '0; e_mcause = '0; e_id = '0; e_redirect = '0;
      m_wait = 0; e_lat_last = 0; e_lat_max = 0;
    end else begin
      e_ack = 0; e_enter = 0; e_complete = 0; e_exit = 0;
      if (m_phase == 0) begin
        if (arb_if.irq_i && mstatus_mie && mie_vec[arb_if.irq_cause_i]) begin
          m_cause = arb_if.irq_cause_i;
          m_extra = arb_if.irq_extra_i;
          m_wait  = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (take_ack) begin
          e_ack = 1; e_enter = 1;
          e_mepc     = epc;
          e_mcause   = 32'h8000_0000 + 32'(m_cause);
          e_id       = m_extra;
          e_redirect = exp_redirect(mtvec, m_cause);
          e_lat_last = m_wait;
          if (m_wait > e_lat_max) e_lat_max = m_wait;
          m_phase = 2;
        end else if (!arb_if.irq_i || !mstatus_mie) begin
          m_phase = 0;
        end else if (m_wait < 65535) begin
          m_wait++;
        end
      end else if (m_phase == 2) begin
        if (mret) begin
          e_complete = 1; e_exit = 1;
          m_phase = 3;
        end
      end else begin
        m_phase = 0;
      end
      e_take_req = (m_phase == 1);
      e_inh      = (m_phase == 2);
    end
  end

  // Compare DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    chk1("take_req_o", take_req, e_take_req);
    chk1("irq_ack_o", arb_if.irq_ack_o, e_ack);
    chk1("irq_complete_o", arb_if.irq_complete_o, e_complete);
    chk1("trap_enter_o", trap_enter, e_enter);
    chk1("trap_exit_o", trap_exit, e_exit);
    chk1("in_handler_o", in_handler, e_inh);
    chk1("ack_and_complete_exclusive", arb_if.irq_ack_o & arb_if.irq_complete_o, 1'b0);
    chk32("mepc_o", mepc, e_mepc);
    chk32("mcause_o", mcause, e_mcause);
    chk32("irq_id_o", irq_id, e_id);
    if (e_enter) chk32("redirect_pc_o", redirect_pc, e_redirect);
`ifdef IRQ_LATENCY_STATS_EN
    chk32("lat_last_o", 32'(lat_last), 32'(e_lat_last));
    chk32("lat_max_o", 32'(lat_max), 32'(e_lat_max));
`endif
    if (arb_if.irq_ack_o) ack_seen++;
  end

  // Advance one clock; inputs change 2 time units after the active edge
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic raise(input logic [4:0] cause, input logic [31:0] extra);
    arb_if.irq_cause_i = cause;
    arb_if.irq_extra_i = extra;
    arb_if.irq_i       = 1'b1;
  endtask

`ifdef IRQ_LATENCY_STATS_EN
  task automatic trap_with_wait(input int wait_cycles);
    raise(CAUSE_MSI, 32'h0);
    cycle();
    repeat (wait_cycles) cycle();
    take_ack = 1'b1;
    cycle();
    take_ack = 1'b0;
    arb_if.irq_i = 1'b0;
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    cycle();
  endtask
`endif

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a0;

  initial begin
    rst_n = 1'b0;
    arb_if.irq_i = 1'b0; arb_if.irq_cause_i = '0; arb_if.irq_extra_i = '0;
    mstatus_mie = 1'b0; mie_vec = '0; mtvec = '0; epc = '0;
    take_ack = 1'b0; mret = 1'b0;
    repeat (3) cycle();
    chk32("reset mepc_o", mepc, 32'h0);
    chk1("reset take_req_o", take_req, 1'b0);
    rst_n = 1'b1;
    cycle();

    // 1: software interrupt, direct mode, ack three cycles after the request
    mstatus_mie = 1'b1; mie_vec = 32'h1 << 3; mtvec = 32'h0000_2000; epc = 32'h100;
    raise(CAUSE_MSI, 32'h0);
    cycle();
    chk1("t1 take_req next cycle", take_req, 1'b1);
    cycle(); cycle();
    take_ack = 1'b1;
    cycle();
    chk1("t1 irq_ack_o", arb_if.irq_ack_o, 1'b1);
    chk32("t1 mepc_o", mepc, 32'h0000_0100);
    chk32("t1 mcause_o", mcause, 32'h8000_0003);
    chk32("t1 redirect direct", redirect_pc, 32'h0000_2000);
    take_ack = 1'b0; arb_if.irq_i = 1'b0;
    cycle();
    chk1("t1 ack one cycle", arb_if.irq_ack_o, 1'b0);
    mret = 1'b1; cycle(); mret = 1'b0;
    cycle();

    // 2: vectored timer interrupt and mret handshake
    mtvec = 32'h0000_1001; mie_vec = 32'h1 << 7; epc = 32'h0000_4444;
    raise(CAUSE_MTI, 32'h0);
    cycle(); cycle();
    take_ack = 1'b1;
    cycle();
    chk32("t2 redirect vectored", redirect_pc, 32'h0000_101C);
    chk1("t2 trap_enter_o", trap_enter, 1'b1);
    take_ack = 1'b0; arb_if.irq_i = 1'b0;
    repeat (3) cycle();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    chk1("t2 irq_complete_o", arb_if.irq_complete_o, 1'b1);
    chk1("t2 trap_exit_o", trap_exit, 1'b1);
    cycle();
    chk1("t2 complete one cycle", arb_if.irq_complete_o, 1'b0);
    chk1("t2 left handler", in_handler, 1'b0);
    cycle();

    // 3: external interrupt, irq held high through the handler
    mie_vec = 32'h1 << 11; mtvec = 32'h0000_3000; epc = 32'h0000_0200;
    raise(CAUSE_MEI, 32'h2);
    cycle();
    take_ack = 1'b1;
    cycle();
    take_ack = 1'b0;
    chk32("t3 irq_id_o", irq_id, 32'h0000_0002);
    cycle();
    a0 = ack_seen;
    repeat (5) cycle();
    chk32("t3 no second ack in handler", 32'(ack_seen), 32'(a0));
    mret = 1'b1; cycle(); mret = 1'b0;
    cycle();
    chk1("t3 no request during cooldown exit", take_req, 1'b0);
    cycle();
    chk1("t3 re-request after done", take_req, 1'b1);
    chk32("t3 still one ack", 32'(ack_seen), 32'(a0));
    take_ack = 1'b1; cycle(); take_ack = 1'b0;
    arb_if.irq_i = 1'b0;
    cycle();
    chk32("t3 second ack after done", 32'(ack_seen), 32'(a0 + 1));
    mret = 1'b1; cycle(); mret = 1'b0;
    cycle();

    // 4: masking by mie bit, by global MIE, and abandon from REQ
    a0 = ack_seen;
    mie_vec = 32'h0; mstatus_mie = 1'b1;
    raise(CAUSE_MTI, 32'h55);
    repeat (20) cycle();
    chk1("t4 masked by mie", take_req, 1'b0);
    mie_vec = 32'h1 << 7; mstatus_mie = 1'b0;
    repeat (20) cycle();
    chk1("t4 masked by MIE", take_req, 1'b0);
    mstatus_mie = 1'b1;
    cycle(); cycle();
    chk1("t4 requesting", take_req, 1'b1);
    mstatus_mie = 1'b0;
    cycle();
    chk1("t4 abandoned", take_req, 1'b0);
    cycle();
    chk32("t4 no ack on abandon", 32'(ack_seen), 32'(a0));
    chk32("t4 irq_id_o unchanged", irq_id, 32'h0000_0002);
    chk32("t4 mcause_o unchanged", mcause, 32'h8000_000B);
    arb_if.irq_i = 1'b0; mstatus_mie = 1'b1;
    cycle();

    // 5: take_ack wins over a simultaneous irq drop, then reset mid-handler
    mie_vec = 32'h1 << 3; epc = 32'h0000_0800; mtvec = 32'h0000_1001;
    raise(CAUSE_MSI, 32'h0);
    cycle();
    take_ack = 1'b1; arb_if.irq_i = 1'b0;
    cycle();
    take_ack = 1'b0;
    chk1("t5 ack despite irq drop", arb_if.irq_ack_o, 1'b1);
    chk32("t5 redirect vectored msi", redirect_pc, 32'h0000_100C);
    cycle();
    chk1("t5 in handler", in_handler, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t5 reset in_handler_o", in_handler, 1'b0);
    chk1("t5 reset take_req_o", take_req, 1'b0);
    chk32("t5 reset mepc_o", mepc, 32'h0);
    chk32("t5 reset mcause_o", mcause, 32'h0);
    chk32("t5 reset redirect_pc_o", redirect_pc, 32'h0);
    cycle();
    rst_n = 1'b1;
    mret = 1'b1; cycle(); mret = 1'b0;
    cycle();
    chk1("t5 mret after reset ignored", arb_if.irq_complete_o, 1'b0);

`ifdef IRQ_LATENCY_STATS_EN
    // 6: latency statistics across three traps
    mie_vec = 32'h1 << 3; mstatus_mie = 1'b1;
    trap_with_wait(2);
    chk32("t6 last after 2", 32'(lat_last), 32'd2);
    trap_with_wait(5);
    chk32("t6 last after 5", 32'(lat_last), 32'd5);
    chk32("t6 max after 5", 32'(lat_max), 32'd5);
    trap_with_wait(1);
    chk32("t6 last after 1", 32'(lat_last), 32'd1);
    chk32("t6 max kept", 32'(lat_max), 32'd5);
`endif

    repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_irq_trap_controller

`default_nettype wire

// File: doc/irq_trap_controller.md
Name: irq_trap_controller

Overview:
Core-side responder for the interrupt arbiter's request interface. It consumes irq/cause/extra, qualifies the request against the CSR enables, and negotiates a trap with the pipeline. It produces the mepc/mcause/redirect values and drives the arbiter's irq_ack and irq_complete handshake. It sits between interrupt_arbiter and the core's CSR file and fetch-redirect logic. Nesting is not supported: one trap is in flight at a time.

Parameters:
XLEN, 32, data/address width.
CAUSE_W, 5, width of the interrupt cause code.
LAT_W, 16, latency counter width (used only with the optional feature).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
irq_i  in  1  level interrupt request from the arbiter.
irq_cause_i  in  CAUSE_W  cause code: 3 = software, 7 = timer, 11 = external.
irq_extra_i  in  XLEN  PLIC claim ID for external interrupts.
irq_ack_o  out  1  one-cycle pulse to the arbiter when the trap is taken.
irq_complete_o  out  1  one-cycle pulse to the arbiter on mret.
mstatus_mie_i  in  1  global interrupt enable.
mie_i  in  XLEN  per-cause enable bits.
mtvec_i  in  XLEN  trap vector; bits [1:0] = mode.
epc_i  in  XLEN  PC of the oldest unretired instruction.
take_req_o  out  1  trap request to the pipeline.
take_ack_i  in  1  pipeline has reached an instruction boundary and flushed.
redirect_pc_o  out  XLEN  fetch target; valid while trap_enter_o is high.
trap_enter_o  out  1  pulse: CSR file sets MPIE<=MIE, MIE<=0, writes mepc/mcause.
mepc_o  out  XLEN  captured epc.
mcause_o  out  XLEN  {1'b1, zeros, cause}.
irq_id_o  out  XLEN  captured irq_extra_i.
mret_i  in  1  mret retired (single-cycle pulse).
trap_exit_o  out  1  pulse: CSR file restores MIE<=MPIE.
in_handler_o  out  1  high while the controller is in the HANDLER state.

Behaviour:
- Reset: all outputs 0, state IDLE, captured registers 0.
- qual = irq_i & mstatus_mie_i & mie_i[irq_cause_i].
- States and transitions:
  - IDLE: when qual = 1, latch cause and extra; go to REQ on the next cycle. Detection latency is one cycle.
  - REQ:
    - take_req_o = 1.
    - On take_ack_i: go to HANDLER. In that same cycle:
      - pulse trap_enter_o and irq_ack_o;
      - load mepc_o <= epc_i, mcause_o, irq_id_o;
      - drive redirect_pc_o.
    - If irq_i = 0 or mstatus_mie_i = 0 without take_ack_i: abandon to IDLE. No ack is issued and the captured registers are unchanged.
    - If take_ack_i and the irq drop occur in the same cycle, take_ack_i wins.
  - HANDLER:
    - in_handler_o = 1; irq_i is ignored.
    - On mret_i: go to DONE and pulse irq_complete_o and trap_exit_o in the same cycle.
  - DONE: one cooldown cycle, outputs idle, then go to IDLE. This lets the arbiter update before irq_i is resampled.
- redirect_pc_o:
  - mtvec mode 0: {mtvec_i[XLEN-1:2], 2'b00}.
  - mtvec mode 1: base + (cause << 2), computed mod 2^XLEN.
  - Modes 2 and 3 are treated as mode 0.
- mret_i outside HANDLER is ignored. take_ack_i outside REQ is ignored.
- irq_ack_o and irq_complete_o never assert in the same cycle. Each assertion is exactly one cycle wide.
- Reset asserted mid-trap returns the block to IDLE with all outputs 0. No complete is sent; the arbiter is reset by the same rst_n.

Optional Feature:
IRQ_LATENCY_STATS_EN
- Defined:
  - Adds outputs lat_last_o[LAT_W-1:0] and lat_max_o[LAT_W-1:0].
  - A counter starts at 0 on the IDLE->REQ transition and increments each cycle in REQ, saturating at all-ones.
  - On take_ack_i: lat_last_o <= count, and lat_max_o <= max(lat_max_o, count).
  - Abandoned requests do not update lat_last_o or lat_max_o.
  - Both outputs reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package irq_pkg contains:
  - cause constants CAUSE_MSI = 3, CAUSE_MTI = 7, CAUSE_MEI = 11;
  - MCAUSE_INT_BIT = XLEN-1;
  - mtvec mode constants;
  - the state enum {IDLE, REQ, HANDLER, DONE}.
- One sub-module, irq_latency_counter, instantiated only under the macro.

Test Plan:
1. Software interrupt, with mie[3] = 1, MIE = 1 and irq cause 3:
   - take_req_o is high on the cycle after irq.
   - With take_ack_i at +3 and epc_i = 0x100, the acknowledge cycle shows irq_ack_o = 1, mepc_o = 0x100 and mcause_o = 0x80000003.
2. Vectored timer interrupt, with mtvec = 0x00001001 and cause 7:
   - redirect_pc_o = 0x0000101C.
   - An mret_i pulse produces irq_complete_o and trap_exit_o for 1 cycle; the block is back in IDLE 2 cycles later.
3. External interrupt with cause 11 and extra = 0x2:
   - irq_id_o = 0x2.
   - A second irq held during HANDLER produces no second ack until after DONE.
4. Masking:
   - With mie[7] = 0 or MIE = 0 and cause 7, take_req_o stays 0 for 20 cycles.
   - Clearing MIE while in REQ abandons the request with no irq_ack_o.
5. Edge cases:
   - take_ack_i in the same cycle as irq_i falling: the trap is taken and the ack is issued.
   - rst_n pulsed while in HANDLER: all outputs read 0 and the state is IDLE.
6. With IRQ_LATENCY_STATS_EN, acks at 2 then 5 cycles give lat_last_o = 5 and lat_max_o = 5. A further ack at 1 cycle gives lat_last_o = 1 and lat_max_o = 5.
